// File: rtl/add_n_if.sv
// Operand bus and registered sum for the add_n reduction tree.
// Element i of inp sits at inp[i*DW +: DW].
interface add_n_if #(
   parameter int N  = 4,
   parameter int DW = 8
);
   logic [N*DW-1:0] inp;
   logic [DW-1:0]   outp;

   modport master (output inp, input outp);
   modport slave  (input inp, output outp);
endinterface

// File: rtl/add_n.sv
// Fully pipelined adder tree: sums N packed DW-bit elements mod 2^DW.
// One register level per tree level; latency max(1, clog2(N)).
module add_n #(
   parameter int N  = 4,
   parameter int DW = 8
) (
   input  logic     clk,
   input  logic     reset,
   add_n_if.slave   bus
);
   function automatic int cnt(input int k);
      return (N + (1 << k) - 1) >> k;
   endfunction

   function automatic int base(input int k);
      int s;
      s = 0;
      for (int m = 0; m < k; m++) s += cnt(m);
      return s;
   endfunction

   localparam int LAT = (N <= 2) ? 1 : $clog2(N);
   localparam int TOT = base(LAT + 1);
   localparam int TOP = base(LAT);

   // Level 0 is the raw operand bus; each later level is registered.
   logic [TOT*DW-1:0] flat;

   assign flat[N*DW-1:0] = bus.inp;

   for (genvar k = 1; k <= LAT; k++) begin : g_lvl
      for (genvar j = 0; j < cnt(k); j++) begin : g_node
         localparam int S = base(k - 1) + 2 * j;
         localparam int D = base(k) + j;
         logic [DW-1:0] q;

         // An unpaired element is delayed so all paths stay aligned.
         if (2 * j + 1 < cnt(k - 1)) begin : g_add
            always_ff @(posedge clk) begin
               if (reset) q <= '0;
               else       q <= flat[S*DW +: DW] + flat[(S+1)*DW +: DW];
            end
         end else begin : g_pass
            always_ff @(posedge clk) begin
               if (reset) q <= '0;
               else       q <= flat[S*DW +: DW];
            end
         end

         assign flat[D*DW +: DW] = q;
      end
   end

   assign bus.outp = flat[TOP*DW +: DW];
endmodule

// File: tb/tb_add_n.sv
// Scoreboard bench for add_n at N=4, N=5 and N=1 (DW=8).
// Expected sums are queued at drive time and popped after each edge.
module tb_add_n;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   add_n_if #(.N(4), .DW(8)) b4 ();
   add_n_if #(.N(5), .DW(8)) b5 ();
   add_n_if #(.N(1), .DW(8)) b1 ();

   add_n #(.N(4), .DW(8)) u4 (.clk(clk), .reset(reset), .bus(b4));
   add_n #(.N(5), .DW(8)) u5 (.clk(clk), .reset(reset), .bus(b5));
   add_n #(.N(1), .DW(8)) u1 (.clk(clk), .reset(reset), .bus(b1));

   int checks = 0;
   int errors = 0;

   logic [7:0] q4[$];
   logic [7:0] q5[$];
   logic [7:0] q1[$];

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] bsum(input logic [63:0] v, input int n);
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < n; i++) s += v[i*8 +: 8];
      return s;
   endfunction

   task automatic push(inout logic [7:0] q[$], input bit r,
                       input int lat, input logic [7:0] v);
      if (r) begin
         q.delete();
         for (int i = 0; i < lat; i++) q.push_back(8'h00);
      end else begin
         q.push_back(v);
      end
   endtask

   task automatic step(input bit r, input logic [31:0] a4,
                       input logic [39:0] a5, input logic [7:0] a1,
                       input string tag);
      @(negedge clk);
      reset  = r;
      b4.inp = a4;
      b5.inp = a5;
      b1.inp = a1;
      push(q4, r, 2, bsum({32'h0, a4}, 4));
      push(q5, r, 3, bsum({24'h0, a5}, 5));
      push(q1, r, 1, a1);
      @(posedge clk);
      #1;
      chk({tag, "_n4"}, b4.outp, q4.pop_front());
      chk({tag, "_n5"}, b5.outp, q5.pop_front());
      chk({tag, "_n1"}, b1.outp, q1.pop_front());
   endtask

   logic [31:0] cnt;
   logic [39:0] r5;

   initial begin
      reset  = 1'b1;
      b4.inp = '0;
      b5.inp = '0;
      b1.inp = '0;

      step(1, 32'h0, 40'h0, 8'h00, "rst");
      step(1, 32'h0, 40'h0, 8'h00, "rst");

      for (int i = 0; i < 4; i++)
         step(0, 32'h04030201, 40'h0504030201, 8'hA5, "hold");

      for (int i = 0; i < 4; i++)
         step(0, 32'hFFFFFFFF, 40'hFFFFFFFFFF, 8'hFF, "ones");

      cnt = 32'h0;
      for (int i = 0; i < 600; i++) begin
         r5 = {$urandom_range(255), $urandom()};
         step(0, cnt, r5, cnt[7:0], "count");
         cnt++;
      end

      r5 = {$urandom_range(255), $urandom()};
      step(1, cnt, r5, cnt[7:0], "midrst");
      cnt++;
      for (int i = 0; i < 12; i++) begin
         r5 = {$urandom_range(255), $urandom()};
         step(0, cnt, r5, cnt[7:0], "resume");
         cnt++;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/add_n.md
Name: add_n

Overview:
- Parameterised, fully pipelined adder tree.
- Sums N packed unsigned elements of DW bits each into one DW-bit result, modulo 2^DW.
- Used as a reduction datapath stage: a flat packed bus in, a single registered sum out.
- New operand set accepted every clock cycle; fixed latency.

Parameters:
- N, 4: number of elements to sum; legal range 1..64.
- DW, 8: width in bits of each element and of the result; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset; clears every pipeline register.
- inp  input  N*DW  packed operands; element i = inp[i*DW +: DW], element 0 in the LSBs.
- outp  output  DW  registered sum of the N elements, modulo 2^DW.

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset), sampled only on the rising edge of clk.
- Latency L = max(1, ceil(log2 N)) clock edges:
  - N=1 -> L=1; N=2 -> L=1; N=4 -> L=2; N=5 -> L=3; N=8 -> L=3.
- Element set present on inp at rising edge t appears on outp immediately after rising edge t+L-1.
- Throughput: one result per cycle; no stalls; no handshake.
- Tree structure:
  - Level 1 pairs elements (0,1), (2,3), ...; each level pairs the previous level's results the same way.
  - Each pair sum is registered at its level.
  - An unpaired odd element at any level is passed through a register at that level so that all paths have equal latency.
  - The final level is a single register driving outp.
  - N=1: outp is a registered copy of element 0.
- Arithmetic:
  - Unsigned; every intermediate sum is truncated to DW bits.
  - The final result equals the sum of all elements mod 2^DW, which is identical to two's-complement wrap.
  - No carry-out or overflow flag.
- Reset:
  - When reset=1 at an edge, every pipeline register loads 0.
  - outp = 0 after that edge; in-flight data is discarded.
- Reset mid-operation:
  - Results from inputs sampled before or during the reset edge never appear on outp.
  - After reset deasserts, outp reads 0 (the sum of cleared stages) until the first post-reset sample reaches the output, L edges later.
  - The first post-reset input is the one sampled at the first edge with reset=0.
- No X propagation from cleared state; all registers are reset.
- Purely combinational addition between register levels; no multicycle paths.

Test Plan:
- N=4, DW=8, reset held 2 cycles -> outp = 0x00 during reset and at the first edge after release.
- N=4, DW=8, inp=0x04030201 held -> outp = 0x0A (1+2+3+4) from the 2nd edge onward.
- N=4, DW=8, inp=0xFFFFFFFF -> outp = 0xFC (1020 mod 256).
- N=4, DW=8, inp driven by a 32-bit up-counter from 0 incremented every edge -> outp at each cycle equals the byte-sum mod 256 of the counter value from 2 edges earlier (e.g. count 0x00000100 -> 0x01, count 0x000001FF -> 0x00).
- N=4, DW=8, counter running, reset asserted for 1 cycle -> outp = 0x00 after the reset edge and the next edge; results resume from the post-reset samples with latency 2.
- N=5, DW=8, inp = {5,4,3,2,1} packed -> outp = 0x0F after 3 edges.
- N=1, DW=8, inp = 0xA5 -> outp = 0xA5 after 1 edge.
